// File: rtl/mul_hilo_unit.sv
// mul_hilo_unit: iterative radix-2 shift-add multiplier with HI/LO registers
// for the mini-MIPS execute stage (MULT/MULTU, MTHI/MTLO, read by MFHI/MFLO).
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   start, is_signed     1-cycle multiply request, MULT(1)/MULTU(0), taken in IDLE only
//   op_a, op_b           multiplicand (rs) / multiplier (rt), sampled with start
//   hi_we/hi_wdata       MTHI write, honoured in IDLE only
//   lo_we/lo_wdata       MTLO write, honoured in IDLE only
//   busy                 high in RUN and FIN (pipeline stall)
//   done                 1-cycle pulse in FIN; hi/lo already hold the product
//   hi, lo               HI / LO registers
//
// Optional feature: define MUL_EARLY_TERM_EN to skip the run once the remaining
// multiplier bits are all zero (results identical, latency shorter).
module mul_hilo_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic [WIDTH-1:0] hi_wdata,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] lo_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   step_full;
  logic [CW-1:0]      step_cnt;
  logic [2*WIDTH-1:0] product;
`ifdef MUL_EARLY_TERM_EN
  logic [WIDTH-1:0]   rem_mask;
`endif

  always_comb begin
    // Magnitudes; -2^(W-1) negates to itself, which read unsigned is exact.
    a_mag = (is_signed && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
    b_mag = (is_signed && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;

    // One shift-add step; the extra acc bit holds the add carry.
    sum       = mplier_q[0] ? (acc_q + {1'b0, mcand_q}) : acc_q;
    step_full = {sum, mplier_q} >> 1;
    step_cnt  = cnt_q - CW'(1);

`ifdef MUL_EARLY_TERM_EN
    // The low cnt_q bits of mplier_q are still unconsumed multiplier bits;
    // if they are all zero the rest of the run only shifts.
    rem_mask = ~({WIDTH{1'b1}} << cnt_q);
    if ((mplier_q & rem_mask) == '0) begin
      step_full = {acc_q, mplier_q} >> cnt_q;
      step_cnt  = '0;
    end
`endif

    product = neg_q ? (~step_full[2*WIDTH-1:0] + (2*WIDTH)'(1))
                    : step_full[2*WIDTH-1:0];

    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = hi_wdata;
        if (lo_we) lo_d = lo_wdata;
        if (start) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = CW'(WIDTH);
          neg_d    = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d    = step_full[2*WIDTH:WIDTH];
        mplier_d = step_full[WIDTH-1:0];
        cnt_d    = step_cnt;
        // Product is written on the same edge that enters FIN so that hi/lo
        // are already valid while done is high.
        if (step_cnt == '0) begin
          hi_d    = product[2*WIDTH-1:WIDTH];
          lo_d    = product[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_hilo_unit.sv
module tb_mul_hilo_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        hi_we;
  logic [31:0] hi_wdata;
  logic        lo_we;
  logic [31:0] lo_wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int bad;

`ifdef MUL_EARLY_TERM_EN
  localparam int LAT_B0 = 2;
  localparam int LAT_B3 = 4;
`else
  localparam int LAT_B0 = 33;
  localparam int LAT_B3 = 33;
`endif

  mul_hilo_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .hi_we(hi_we), .hi_wdata(hi_wdata),
    .lo_we(lo_we), .lo_wdata(lo_wdata), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one multiply and observe a fixed 40-cycle window (cycle 1 is the
  // cycle after the edge that samples start).
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int lat, output int pulses,
                         output logic [31:0] hi_at, output logic [31:0] lo_at);
    @(negedge clk);
    op_a = a; op_b = b; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; pulses = 0; hi_at = 'x; lo_at = 'x;
    for (int c = 1; c <= 40; c++) begin
      if (done === 1'b1) begin
        if (pulses == 0) begin lat = c; hi_at = hi; lo_at = lo; end
        pulses++;
      end
      if (c < 40) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL reset_hilo got=%h_%h exp=0_0", hi, lo); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_multu();
    int lat, pulses; logic [31:0] h, l;
    run_mul(32'd5, 32'd7, 1'b0, lat, pulses, h, l);
    total++; if (lat !== 33) begin bad++; $display("FAIL multu_lat got=%0d exp=33", lat); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL multu_pulses got=%0d exp=1", pulses); end
    total++; if (h !== 32'h0 || l !== 32'h23) begin bad++; $display("FAIL multu_5x7 got=%h_%h exp=00000000_00000023", h, l); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL multu_idle_busy got=%0b exp=0", busy); end
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, lat, pulses, h, l);
    total++; if (h !== 32'hFFFFFFFD || l !== 32'h2) begin bad++; $display("FAIL multu_max got=%h_%h exp=fffffffd_00000002", h, l); end
  endtask

  task automatic test_mult_signed();
    int lat, pulses; logic [31:0] h, l;
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, lat, pulses, h, l);
    total++; if (h !== 32'h0 || l !== 32'h2) begin bad++; $display("FAIL mult_m1xm2 got=%h_%h exp=00000000_00000002", h, l); end
    run_mul(32'h80000000, 32'h80000000, 1'b1, lat, pulses, h, l);
    total++; if (h !== 32'h40000000 || l !== 32'h0) begin bad++; $display("FAIL mult_minxmin got=%h_%h exp=40000000_00000000", h, l); end
    run_mul(32'hFFFFFFFF, 32'd7, 1'b1, lat, pulses, h, l);
    total++; if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFF9) begin bad++; $display("FAIL mult_m1x7 got=%h_%h exp=ffffffff_fffffff9", h, l); end
    total++; if (lat !== 33) begin bad++; $display("FAIL mult_lat got=%0d exp=33", lat); end
  endtask

  task automatic test_mthi_mtlo();
    int c;
    @(negedge clk);
    hi_we = 1'b1; hi_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    hi_we = 1'b0;
    total++; if (hi !== 32'hDEADBEEF) begin bad++; $display("FAIL mthi got=%h exp=deadbeef", hi); end
    total++; if (lo !== 32'hFFFFFFF9) begin bad++; $display("FAIL mthi_lo_kept got=%h exp=fffffff9", lo); end
    @(negedge clk);
    hi_we = 1'b1; hi_wdata = 32'h11111111; lo_we = 1'b1; lo_wdata = 32'h22222222;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++; if (hi !== 32'h11111111 || lo !== 32'h22222222) begin bad++; $display("FAIL mthilo_hold got=%h_%h exp=11111111_22222222", hi, lo); end
    // start and MTHI in the same idle cycle: write lands, product overwrites later
    @(negedge clk);
    op_a = 32'd5; op_b = 32'd7; is_signed = 1'b0; start = 1'b1;
    hi_we = 1'b1; hi_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    total++; if (hi !== 32'hCAFEF00D) begin bad++; $display("FAIL start_mthi_same got=%h exp=cafef00d", hi); end
    c = 1;
    while (done !== 1'b1 && c < 40) begin @(posedge clk); #1; c++; end
    total++; if (c !== 33 || hi !== 32'h0 || lo !== 32'h23) begin bad++; $display("FAIL start_mthi_fin got=cyc%0d %h_%h exp=cyc33 00000000_00000023", c, hi, lo); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat, pulses, busy_after;
    logic [31:0] h, l;
    @(negedge clk);
    op_a = 32'd5; op_b = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; pulses = 0; busy_after = -1; h = 'x; l = 'x;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) begin
        start = 1'b1; op_a = 32'd9; op_b = 32'd9;
        hi_we = 1'b1; hi_wdata = 32'hDEADBEEF; lo_we = 1'b1; lo_wdata = 32'hDEADBEEF;
      end
      if (c == 6) begin start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; end
      if (lat != 0 && c == lat + 1) begin busy_after = int'(busy); start = 1'b0; end
      if (done === 1'b1) begin
        if (pulses == 0) begin
          lat = c; h = hi; l = lo;
          start = 1'b1; op_a = 32'd3; op_b = 32'd3;  // start during FIN: ignored
        end
        pulses++;
      end
      if (c < 40) begin @(posedge clk); #1; end
    end
    start = 1'b0;
    total++; if (pulses !== 1) begin bad++; $display("FAIL b2b_pulses got=%0d exp=1", pulses); end
    total++; if (lat !== 33) begin bad++; $display("FAIL b2b_lat got=%0d exp=33", lat); end
    total++; if (h !== 32'h0 || l !== 32'h23) begin bad++; $display("FAIL b2b_result got=%h_%h exp=00000000_00000023", h, l); end
    total++; if (busy_after !== 0) begin bad++; $display("FAIL b2b_fin_start got=busy%0d exp=busy0", busy_after); end
    total++; if (hi !== 32'h0 || lo !== 32'h23) begin bad++; $display("FAIL b2b_dropped_we got=%h_%h exp=00000000_00000023", hi, lo); end
  endtask

  task automatic test_async_reset();
    int lat, pulses, early_done;
    logic [31:0] h, l;
    run_mul(32'hFFFFFFFF, 32'd7, 1'b1, lat, pulses, h, l);
    @(negedge clk);
    op_a = 32'd3; op_b = 32'd3; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL areset_ctl got=busy%0b done%0b exp=busy0 done0", busy, done); end
    total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL areset_hilo got=%h_%h exp=0_0", hi, lo); end
    @(negedge clk);
    reset_n = 1'b1;
    early_done = 0;
    for (int c = 0; c < 30; c++) begin @(posedge clk); #1; if (done === 1'b1) early_done++; end
    total++; if (early_done !== 0 || hi !== 32'h0) begin bad++; $display("FAIL areset_no_done got=%0d hi=%h exp=0 hi=0", early_done, hi); end
    run_mul(32'd6, 32'd7, 1'b0, lat, pulses, h, l);
    total++; if (lat !== 33 || h !== 32'h0 || l !== 32'd42) begin bad++; $display("FAIL areset_next got=cyc%0d %h_%h exp=cyc33 00000000_0000002a", lat, h, l); end
  endtask

  task automatic test_early_term();
    int lat, pulses; logic [31:0] h, l;
    run_mul(32'h12345678, 32'h0, 1'b0, lat, pulses, h, l);
    total++; if (lat !== LAT_B0) begin bad++; $display("FAIL et_zero_lat got=%0d exp=%0d", lat, LAT_B0); end
    total++; if (h !== 32'h0 || l !== 32'h0) begin bad++; $display("FAIL et_zero_res got=%h_%h exp=0_0", h, l); end
    run_mul(32'd7, 32'd3, 1'b0, lat, pulses, h, l);
    total++; if (lat !== LAT_B3) begin bad++; $display("FAIL et_7x3_lat got=%0d exp=%0d", lat, LAT_B3); end
    total++; if (h !== 32'h0 || l !== 32'h15) begin bad++; $display("FAIL et_7x3_res got=%h_%h exp=00000000_00000015", h, l); end
    run_mul(32'hFFFFFFF9, 32'd3, 1'b1, lat, pulses, h, l);
    total++; if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFEB) begin bad++; $display("FAIL et_m7x3_res got=%h_%h exp=ffffffff_ffffffeb", h, l); end
  endtask

  initial begin
    total = 0; bad = 0;
    start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    hi_we = 1'b0; hi_wdata = '0; lo_we = 1'b0; lo_wdata = '0;
    reset_n = 1'b0;
    test_reset();
    test_multu();
    test_mult_signed();
    test_mthi_mtlo();
    test_back_to_back();
    test_async_reset();
    test_early_term();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
